garage_door_cmd_arbiter: RTL and testbench



---
 rtl/gdc_pkg.sv | 41 ++++
 rtl/gdc_req_edge.sv | 31 +++
 rtl/garage_door_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_garage_door_cmd_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gdc_pkg.sv
// Shared types for the garage door command arbiter: FSM states, requester
// indices, travel direction and small decision helpers.
package gdc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MV_UP   = 3'd1,
        MV_DN   = 3'd2,
        STOPPED = 3'd3,
        FAULT   = 3'd4
    } gdc_state_e;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } gdc_dir_e;

    localparam int unsigned REQ_WALL   = 0;
    localparam int unsigned REQ_REMOTE = 1;
    localparam int unsigned REQ_AUTO   = 2;

    // Fixed priority wall > remote > auto; returns one-hot of the winner.
    function automatic logic [2:0] pick_first(input logic [2:0] pend);
        logic [2:0] win;
        win = '0;
        if (pend[REQ_WALL])        win[REQ_WALL]   = 1'b1;
        else if (pend[REQ_REMOTE]) win[REQ_REMOTE] = 1'b1;
        else if (pend[REQ_AUTO])   win[REQ_AUTO]   = 1'b1;
        return win;
    endfunction

    // Mid-travel (no limit active) reverses the last direction of motion.
    function automatic gdc_state_e start_state(input logic up_max, input logic dn_max,
                                               input gdc_dir_e last_dir);
        if (dn_max && !up_max)      return MV_UP;
        else if (up_max && !dn_max) return MV_DN;
        else if (last_dir == DIR_UP) return MV_DN;
        else                        return MV_UP;
    endfunction

endpackage

// File: rtl/gdc_req_edge.sv
// Rising-edge detector feeding a pending-request latch; a new edge is only
// accepted while en_i is high, and clr_i drops a held request.
module gdc_req_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic en_i,
    input  logic clr_i,
    output logic pend_o
);

    logic prev_q;
    logic pend_q, pend_d;

    always_comb begin
        pend_d = ((req_i & ~prev_q) & en_i) | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= req_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/garage_door_cmd_arbiter.sv
// Garage door motor sequencer arbitrating wall, remote and auto-close requests,
// with run watchdog, obstruction reversal and latched fault.
// Auto-close timer is built only when GDC_AUTO_CLOSE_EN is defined.
module garage_door_cmd_arbiter
    import gdc_pkg::*;
#(
    parameter int RUN_TMO    = 50000,
    parameter int RUN_W      = 16,
    parameter int AUTO_CLOSE = 100000,
    parameter int CLOSE_W    = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Wall_Req,
    input  logic       Remote_Req,
    input  logic       UP_Max,
    input  logic       DN_MAX,
    input  logic       Obstruct,
    output logic       UP_M,
    output logic       DN_M,
    output logic [2:0] Grant,
    output logic       Busy,
    output logic       Fault
);

    if (RUN_TMO < 2 || (RUN_TMO - 1) >= (1 << RUN_W)) begin : g_bad_run_w
        $error("RUN_W too narrow for RUN_TMO");
    end
    if (AUTO_CLOSE < 2 || (AUTO_CLOSE - 1) >= (1 << CLOSE_W)) begin : g_bad_close_w
        $error("CLOSE_W too narrow for AUTO_CLOSE");
    end

    gdc_state_e       state_q, state_d;
    gdc_dir_e         last_dir_q, last_dir_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       pend;
    logic             moving, flush, run_hit;

    assign moving  = (state_q == MV_UP) || (state_q == MV_DN);
    assign flush   = (state_q == FAULT);
    assign run_hit = moving && (run_q == RUN_W'(RUN_TMO - 1));

    gdc_req_edge u_wall (
        .clk    (CLK),
        .rst_n  (RST),
        .req_i  (Wall_Req),
        .en_i   (!flush),
        .clr_i  (grant_d[REQ_WALL] | flush),
        .pend_o (pend[REQ_WALL])
    );

    gdc_req_edge u_remote (
        .clk    (CLK),
        .rst_n  (RST),
        .req_i  (Remote_Req),
        .en_i   (!flush),
        .clr_i  (grant_d[REQ_REMOTE] | flush),
        .pend_o (pend[REQ_REMOTE])
    );

`ifdef GDC_AUTO_CLOSE_EN
    logic [CLOSE_W-1:0] close_q, close_d;
    logic               auto_pend_q, auto_pend_d;
    logic               close_hit;

    // An auto request raised while the door is moving is discarded, not queued.
    always_comb begin
        close_d   = '0;
        close_hit = 1'b0;
        if (state_q == IDLE && UP_Max && !DN_MAX && !Obstruct) begin
            if (close_q == CLOSE_W'(AUTO_CLOSE - 1)) close_hit = 1'b1;
            else                                     close_d   = close_q + CLOSE_W'(1);
        end
        auto_pend_d = close_hit | (auto_pend_q & ~(grant_d[REQ_AUTO] | flush | moving));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            close_q     <= '0;
            auto_pend_q <= 1'b0;
        end else begin
            close_q     <= close_d;
            auto_pend_q <= auto_pend_d;
        end
    end

    assign pend[REQ_AUTO] = auto_pend_q;
`else
    assign pend[REQ_AUTO] = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        last_dir_d = last_dir_q;
        if (UP_Max && DN_MAX) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE, STOPPED: begin
                    if (|pend) begin
                        grant_d = pick_first(pend);
                        state_d = start_state(UP_Max, DN_MAX, last_dir_q);
                    end
                end
                MV_UP: begin
                    if (UP_Max)                                state_d = IDLE;
                    else if (run_hit)                          state_d = FAULT;
                    else if (pend[REQ_WALL] | pend[REQ_REMOTE]) begin
                        grant_d = pick_first({1'b0, pend[REQ_REMOTE], pend[REQ_WALL]});
                        state_d = STOPPED;
                    end
                end
                MV_DN: begin
                    // Reversal outranks a stop request; that request stays pending.
                    if (DN_MAX)                                state_d = IDLE;
                    else if (run_hit)                          state_d = FAULT;
                    else if (Obstruct)                         state_d = MV_UP;
                    else if (pend[REQ_WALL] | pend[REQ_REMOTE]) begin
                        grant_d = pick_first({1'b0, pend[REQ_REMOTE], pend[REQ_WALL]});
                        state_d = STOPPED;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
        if (state_d == MV_UP) last_dir_d = DIR_UP;
        if (state_d == MV_DN) last_dir_d = DIR_DN;
        if ((state_d == MV_UP || state_d == MV_DN) && state_d == state_q)
            run_d = run_q + RUN_W'(1);
        else
            run_d = '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            last_dir_q <= DIR_DN;
            run_q      <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            run_q      <= run_d;
            grant_q    <= grant_d;
        end
    end

    assign UP_M  = (state_q == MV_UP);
    assign DN_M  = (state_q == MV_DN);
    assign Busy  = moving;
    assign Fault = flush;
    assign Grant = grant_q;

endmodule

// File: tb/tb_garage_door_cmd_arbiter.sv
// Directed bench for garage_door_cmd_arbiter with RUN_TMO=20, AUTO_CLOSE=10;
// expected values are hand-computed per step.
module tb_garage_door_cmd_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Wall_Req = 1'b0;
    logic       Remote_Req = 1'b0;
    logic       UP_Max = 1'b0;
    logic       DN_MAX = 1'b0;
    logic       Obstruct = 1'b0;
    logic       UP_M, DN_M, Busy, Fault;
    logic [2:0] Grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    garage_door_cmd_arbiter #(
        .RUN_TMO    (20),
        .RUN_W      (16),
        .AUTO_CLOSE (10),
        .CLOSE_W    (20)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Wall_Req   (Wall_Req),
        .Remote_Req (Remote_Req),
        .UP_Max     (UP_Max),
        .DN_MAX     (DN_MAX),
        .Obstruct   (Obstruct),
        .UP_M       (UP_M),
        .DN_M       (DN_M),
        .Grant      (Grant),
        .Busy       (Busy),
        .Fault      (Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input logic up, input logic dn, input logic ob);
        RST        = 1'b0;
        Wall_Req   = 1'b0;
        Remote_Req = 1'b0;
        UP_Max     = up;
        DN_MAX     = dn;
        Obstruct   = ob;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        // Reset values while held in reset
        do_reset(1'b0, 1'b1, 1'b0);
        RST = 1'b0;
        #2;
        chk("rst_up_m",  UP_M,  0);
        chk("rst_dn_m",  DN_M,  0);
        chk("rst_grant", Grant, 0);
        chk("rst_busy",  Busy,  0);
        chk("rst_fault", Fault, 0);

        // Closed door, wall pulse: pending at A, MV_UP + grant 001 at B
        do_reset(1'b0, 1'b1, 1'b0);
        tick(1);
        Wall_Req = 1'b1;
        tick(1);
        chk("t1_nogrant_yet", Grant, 0);
        chk("t1_no_motor_yet", UP_M, 0);
        Wall_Req = 1'b0;
        tick(1);
        chk("t1_grant", Grant, 3'b001);
        chk("t1_up_m",  UP_M,  1);
        chk("t1_busy",  Busy,  1);
        chk("t1_dn_m",  DN_M,  0);
        tick(1);
        chk("t1_grant_1cyc", Grant, 0);
        chk("t1_still_up",   UP_M,  1);
        UP_Max = 1'b1;
        DN_MAX = 1'b0;
        tick(1);
        chk("t1_limit_up_m", UP_M, 0);
        chk("t1_limit_busy", Busy, 0);

        // Wall+remote together: wall wins, remote survives the limit stop
        do_reset(1'b0, 1'b1, 1'b0);
        tick(1);
        Wall_Req   = 1'b1;
        Remote_Req = 1'b1;
        tick(1);
        Wall_Req   = 1'b0;
        Remote_Req = 1'b0;
        tick(1);
        chk("t2_grant_wall", Grant, 3'b001);
        chk("t2_up_m",       UP_M,  1);
        UP_Max = 1'b1;
        DN_MAX = 1'b0;
        tick(1);
        chk("t2_limit_idle", UP_M,  0);
        chk("t2_limit_nog",  Grant, 0);
        tick(1);
        chk("t2_grant_rem", Grant, 3'b010);
        chk("t2_dn_m",      DN_M,  1);
        UP_Max = 1'b0;

        // Obstruction reversal in MV_DN, then watchdog from the cleared counter
        tick(1);
        chk("t3_still_dn", DN_M, 1);
        Obstruct = 1'b1;
        tick(1);
        chk("t3_rev_up_m",  UP_M,  1);
        chk("t3_rev_dn_m",  DN_M,  0);
        chk("t3_rev_grant", Grant, 0);
        Obstruct = 1'b0;
        tick(19);
        chk("t4_pre_fault", Fault, 0);
        chk("t4_pre_up_m",  UP_M,  1);
        tick(1);
        chk("t4_fault",   Fault, 1);
        chk("t4_up_m_0",  UP_M,  0);
        chk("t4_dn_m_0",  DN_M,  0);
        chk("t4_busy_0",  Busy,  0);
        Wall_Req = 1'b1;
        tick(1);
        Wall_Req = 1'b0;
        tick(2);
        chk("t4_wall_ignored", Grant, 0);
        chk("t4_fault_held",   Fault, 1);
        chk("t4_motor_off",    UP_M,  0);

        // Stop mid-travel, reverse on second pulse, reversal-vs-pending, async reset
        do_reset(1'b0, 1'b1, 1'b0);
        tick(1);
        Wall_Req = 1'b1;
        tick(1);
        Wall_Req = 1'b0;
        tick(1);
        chk("t5_moving_up", UP_M, 1);
        DN_MAX     = 1'b0;
        Remote_Req = 1'b1;
        tick(1);
        Remote_Req = 1'b0;
        tick(1);
        chk("t5_stop_grant", Grant, 3'b010);
        chk("t5_stop_up_m",  UP_M,  0);
        chk("t5_stop_busy",  Busy,  0);
        Remote_Req = 1'b1;
        tick(1);
        Remote_Req = 1'b0;
        tick(1);
        chk("t5_rev_grant", Grant, 3'b010);
        chk("t5_rev_dn_m",  DN_M,  1);
        Wall_Req = 1'b1;
        tick(1);
        Wall_Req = 1'b0;
        Obstruct = 1'b1;
        tick(1);
        chk("t6_obs_wins_up", UP_M,  1);
        chk("t6_obs_nogrant", Grant, 0);
        Obstruct = 1'b0;
        tick(1);
        chk("t6_kept_grant", Grant, 3'b001);
        chk("t6_kept_stop",  Busy,  0);
        Wall_Req = 1'b1;
        tick(1);
        Wall_Req = 1'b0;
        tick(1);
        chk("t7_dn_again", DN_M, 1);
        #3;
        RST = 1'b0;
        #1;
        chk("t7_async_dn_m",  DN_M,  0);
        chk("t7_async_busy",  Busy,  0);

        // Both limits asserted at once forces FAULT
        do_reset(1'b0, 1'b1, 1'b0);
        tick(1);
        UP_Max = 1'b1;
        tick(1);
        chk("t8_both_limits", Fault, 1);

`ifdef GDC_AUTO_CLOSE_EN
        do_reset(1'b1, 1'b0, 1'b0);
        tick(10);
        chk("t9_ac_wait_grant", Grant, 0);
        chk("t9_ac_wait_dn",    DN_M,  0);
        tick(1);
        chk("t9_ac_grant", Grant, 3'b100);
        chk("t9_ac_dn_m",  DN_M,  1);
        do_reset(1'b1, 1'b0, 1'b1);
        tick(15);
        chk("t9_ac_obs_grant", Grant, 0);
        chk("t9_ac_obs_dn",    DN_M,  0);
`else
        do_reset(1'b1, 1'b0, 1'b0);
        tick(15);
        chk("t9_no_ac_grant", Grant, 0);
        chk("t9_no_ac_dn",    DN_M,  0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
